// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single-read-port registered ROM: fetch (A) has
// priority, data-side loads (B) are protected from starvation by an age counter.
module rom_port_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 10,
    parameter int max_wait   = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_a,
    input  logic [addr_width-1:0] addr_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [data_width-1:0] rdata_a,
    input  logic                  req_b,
    input  logic [addr_width-1:0] addr_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [data_width-1:0] rdata_b,
    output logic [addr_width-1:0] rom_addr,
    input  logic [data_width-1:0] rom_data,
    output logic                  b_forced
);

    localparam logic [3:0] MAX_WAIT = 4'(max_wait);

    logic [3:0]            age_q, age_d;
    logic                  tag_a_q, tag_a_d;
    logic                  tag_b_q, tag_b_d;
    logic                  rvalid_a_q, rvalid_a_d;
    logic                  rvalid_b_q, rvalid_b_d;
    logic [data_width-1:0] rdata_a_q, rdata_a_d;
    logic [data_width-1:0] rdata_b_q, rdata_b_d;
    logic                  force_b;

    always_comb begin
        force_b  = req_b && (age_q >= MAX_WAIT);
        gnt_b    = req_b && (force_b || !req_a);
        gnt_a    = req_a && !gnt_b;
        rom_addr = gnt_b ? addr_b : addr_a;
        b_forced = gnt_b && req_a;
    end

    // The tag pipelines the grant alongside the ROM's own read register so the
    // returned word is steered to whichever port owned the address.
    always_comb begin
        age_d      = 4'd0;
        if (req_b && !gnt_b) begin
            age_d = (age_q == 4'hF) ? age_q : age_q + 4'd1;
        end
        tag_a_d    = gnt_a;
        tag_b_d    = gnt_b;
        rvalid_a_d = tag_a_q;
        rvalid_b_d = tag_b_q;
        rdata_a_d  = tag_a_q ? rom_data : rdata_a_q;
        rdata_b_d  = tag_b_q ? rom_data : rdata_b_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            age_q      <= 4'd0;
            tag_a_q    <= 1'b0;
            tag_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            age_q      <= age_d;
            tag_a_q    <= tag_a_d;
            tag_b_q    <= tag_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered ROM model holding 0x1000 + address.
module tb_rom_port_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        req_a;
    logic [9:0]  addr_a;
    logic        gnt_a;
    logic        rvalid_a;
    logic [31:0] rdata_a;
    logic        req_b;
    logic [9:0]  addr_b;
    logic        gnt_b;
    logic        rvalid_b;
    logic [31:0] rdata_b;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        b_forced;

    logic [31:0] rom [0:1023];
    int checkCount;
    int errorCount;

    rom_port_arbiter #(.data_width(32), .addr_width(10), .max_wait(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .rom_addr(rom_addr), .rom_data(rom_data), .b_forced(b_forced)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) rom_data <= rom[rom_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic applyStimulus(input logic rst_n, input logic ra, input logic [9:0] aa,
                                 input logic rb, input logic [9:0] ab);
        @(negedge CLK);
        RST_N  = rst_n;
        req_a  = ra;
        addr_a = aa;
        req_b  = rb;
        addr_b = ab;
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h1000 + 32'(i);
        RST_N = 1'b0; req_a = 1'b0; addr_a = '0; req_b = 1'b0; addr_b = '0;

        // Reset and single fetch
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("reset_rvalid_b", 32'(rvalid_b), 32'd0);
        checkOutput("reset_rdata_a", rdata_a, 32'd0);
        checkOutput("reset_rdata_b", rdata_b, 32'd0);
        applyStimulus(1'b1, 1'b1, 10'd5, 1'b0, 10'd0);
        checkOutput("single_gnt_a", 32'(gnt_a), 32'd1);
        checkOutput("single_gnt_b", 32'(gnt_b), 32'd0);
        checkOutput("single_rom_addr", 32'(rom_addr), 32'd5);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("single_rvalid_a_early", 32'(rvalid_a), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("single_rvalid_a", 32'(rvalid_a), 32'd1);
        checkOutput("single_rdata_a", rdata_a, 32'h1005);
        checkOutput("single_rvalid_b", 32'(rvalid_b), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("single_rvalid_a_pulse", 32'(rvalid_a), 32'd0);
        checkOutput("single_rdata_a_hold", rdata_a, 32'h1005);

        // Streaming fetch of addresses 0..7
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, i < 8, 10'(i), 1'b0, 10'd0);
            if (i < 8) checkOutput("stream_gnt_a", 32'(gnt_a), 32'd1);
            checkOutput("stream_rvalid_a", 32'(rvalid_a), 32'(i >= 2));
            if (i >= 2) checkOutput("stream_rdata_a", rdata_a, 32'h1000 + 32'(i - 2));
            checkOutput("stream_rvalid_b", 32'(rvalid_b), 32'd0);
        end

        // Contention with aging: B forced every fifth cycle
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, 1'b1, 10'h010, 1'b1, 10'h3FF);
            checkOutput("aging_gnt_b", 32'(gnt_b), 32'((k % 5) == 4));
            checkOutput("aging_gnt_a", 32'(gnt_a), 32'((k % 5) != 4));
            checkOutput("aging_b_forced", 32'(b_forced), 32'((k % 5) == 4));
            checkOutput("aging_rvalid_b", 32'(rvalid_b), 32'(k >= 2 && ((k - 2) % 5) == 4));
            checkOutput("aging_rvalid_a", 32'(rvalid_a), 32'(k >= 2 && ((k - 2) % 5) != 4));
            if (k >= 2 && ((k - 2) % 5) == 4) checkOutput("aging_rdata_b", rdata_b, 32'h13FF);
            if (k >= 2 && ((k - 2) % 5) != 4) checkOutput("aging_rdata_a", rdata_a, 32'h1010);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);

        // B alone, then A arrives
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b1, 10'd3);
        checkOutput("balone_gnt_b", 32'(gnt_b), 32'd1);
        checkOutput("balone_b_forced", 32'(b_forced), 32'd0);
        checkOutput("balone_rom_addr", 32'(rom_addr), 32'd3);
        applyStimulus(1'b1, 1'b1, 10'd4, 1'b0, 10'd0);
        checkOutput("balone_gnt_a", 32'(gnt_a), 32'd1);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("balone_rvalid_b", 32'(rvalid_b), 32'd1);
        checkOutput("balone_rdata_b", rdata_b, 32'h1003);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("balone_rvalid_a", 32'(rvalid_a), 32'd1);
        checkOutput("balone_rdata_a", rdata_a, 32'h1004);
        checkOutput("balone_rvalid_b_pulse", 32'(rvalid_b), 32'd0);

        // Reset while a fetch is in flight
        applyStimulus(1'b1, 1'b1, 10'd6, 1'b0, 10'd0);
        checkOutput("rstmid_gnt_a", 32'(gnt_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("rstmid_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("rstmid_rdata_a", rdata_a, 32'd0);
        checkOutput("rstmid_rdata_b", rdata_b, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b1, 10'd9);
        checkOutput("rstmid_gnt_b", 32'(gnt_b), 32'd1);
        checkOutput("rstmid_b_forced", 32'(b_forced), 32'd0);
        checkOutput("rstmid_rvalid_a2", 32'(rvalid_a), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("rstmid_rvalid_a3", 32'(rvalid_a), 32'd0);
        checkOutput("rstmid_rvalid_b_early", 32'(rvalid_b), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("rstmid_rvalid_b", 32'(rvalid_b), 32'd1);
        checkOutput("rstmid_rdata_b2", rdata_b, 32'h1009);
        checkOutput("rstmid_rvalid_a4", 32'(rvalid_a), 32'd0);
        checkOutput("rstmid_rdata_a2", rdata_a, 32'd0);

        // Withdrawal: B pending two cycles, dropped, then a fresh wait of four
        for (int g = 0; g < 8; g++) begin
            applyStimulus(1'b1, 1'b1, 10'h020, g != 2, 10'h030);
            checkOutput("withdraw_gnt_b", 32'(gnt_b), 32'(g == 7));
            checkOutput("withdraw_b_forced", 32'(b_forced), 32'(g == 7));
            checkOutput("withdraw_rvalid_b", 32'(rvalid_b), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("withdraw_rvalid_b_early", 32'(rvalid_b), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
        checkOutput("withdraw_rvalid_b_final", 32'(rvalid_b), 32'd1);
        checkOutput("withdraw_rdata_b", rdata_b, 32'h1030);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one registered instruction ROM (single read port, 1-cycle read latency) between two requesters:
  - port A: instruction fetch.
  - port B: data-side constant/literal loads from the pipeline's memory stage.
- Sits between the pipeline and the ROM instance.
- Issues at most one ROM read per cycle and routes the returned word to the owning port one cycle later.
- Default priority goes to fetch. An age counter prevents port B from starving.

Parameters:
- data_width, 32, ROM word width.
- addr_width, 10, ROM word-address width.
- max_wait, 4, consecutive cycles port B may be denied before it is forced to win; must be 1..15.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  synchronous active-low reset.
- req_a  input  1  port A read request.
- addr_a  input  addr_width  port A word address; stable while req_a is high and gnt_a is low.
- gnt_a  output  1  port A request accepted this cycle (combinational).
- rvalid_a  output  1  rdata_a carries port A's data this cycle.
- rdata_a  output  data_width  port A read data.
- req_b  input  1  port B read request.
- addr_b  input  addr_width  port B word address; same stability rule.
- gnt_b  output  1  port B request accepted this cycle (combinational).
- rvalid_b  output  1  rdata_b carries port B's data this cycle.
- rdata_b  output  data_width  port B read data.
- rom_addr  output  addr_width  address to the ROM iaddr.
- rom_data  input  data_width  ROM idata (registered inside the ROM).
- b_forced  output  1  debug: the current grant to B was forced by aging.

Behaviour:
- Reset (RST_N low at posedge):
  - Clears rvalid_a, rvalid_b, the in-flight tag and the age counter.
  - Sets rdata_a and rdata_b to 0.
  - Combinational outputs are still computed during reset, but grants issued while RST_N is low have no effect:
    - No rvalid follows from them.
    - They are not counted as served.
  - An in-flight read is dropped when reset is asserted; its rvalid never appears.
- Grant (combinational, every cycle):
  - force_b = req_b && (age >= max_wait).
  - gnt_b = req_b && (force_b || !req_a).
  - gnt_a = req_a && !gnt_b.
  - gnt_a and gnt_b are never both 1.
- ROM address mux:
  - rom_addr = addr_b if gnt_b, else addr_a.
  - When idle, rom_addr still follows addr_a (harmless read).
- b_forced = gnt_b && req_a. It is high only when B wins over a pending A.
- Age counter (4-bit):
  - On posedge with reset deasserted:
    - req_b && !gnt_b: age increments, saturating at 15.
    - gnt_b or !req_b: age clears to 0.
- Response tracking:
  - On posedge, a tag register records {gnt_a, gnt_b}.
  - In the next cycle the ROM presents rom_data for that address.
- Response outputs (registered on the following posedge, giving 2-cycle grant-to-rvalid latency):
  - rvalid_a <= tag_a.
  - rvalid_b <= tag_b.
  - If tag_a: rdata_a <= rom_data. If tag_b: rdata_b <= rom_data.
  - Fixed timing: request granted at cycle N; ROM samples the address at edge N; rom_data is valid in cycle N+1; rvalid/rdata are high in cycle N+2.
- rdata_x holds its last returned value until the next rvalid_x. rvalid_x is a single-cycle pulse per grant.
- Back-to-back: one grant per cycle sustains full throughput. Responses come out in grant order with no reordering.
- Requester contract:
  - A port may re-request, with a new address, in the cycle after its grant.
  - A request with gnt low must be held.
  - Dropping req before gnt is allowed; it withdraws the request without side effects.
- Simultaneous req_a and req_b with age < max_wait: A wins, B ages.
- After max_wait denials, B wins exactly once and age clears.

Test Plan:
- Reset, single-port fetch:
  - Stimulus: ROM preloaded with rom[i] = 0x1000 + i. RST_N low 3 cycles, outputs checked 0. Then req_a with addr_a = 5 for one cycle.
  - Required: gnt_a = 1 same cycle; rvalid_a pulses 2 cycles later with rdata_a = 0x1005; rvalid_b stays 0.
- Streaming fetch:
  - Stimulus: req_a held high with addr_a = 0, 1, 2, …, 7 advanced after each grant.
  - Required: eight consecutive rvalid_a pulses with rdata_a = 0x1000..0x1007 in order, no gaps.
- Contention and aging (max_wait = 4):
  - Stimulus: req_a and req_b held continuously, addr_b = 0x3FF.
  - Required: gnt_a for 4 cycles, then gnt_b with b_forced = 1 in cycle 5. rvalid_b fires 2 cycles later with rdata_b = 0x13FF. The pattern repeats every 5 cycles.
- B alone, then A arrives:
  - Stimulus: req_b only (addr_b = 3), then req_a (addr_a = 4) the following cycle.
  - Required: gnt_b immediately with b_forced = 0; A granted next cycle; rdata_b = 0x1003 and rdata_a = 0x1004 on consecutive cycles.
- Reset mid-flight:
  - Stimulus: grant A (addr 6), assert RST_N low in the next cycle.
  - Required: rvalid_a never pulses, rdata_a = 0, age = 0.
  - After release, B is served immediately with no stale response.
- Withdrawal:
  - Stimulus: req_b raised during contention for 2 cycles, then dropped before grant.
  - Required: no gnt_b, no rvalid_b, age back to 0; the next B request waits a fresh 4 cycles.
